seqdet_prog: RTL
================

Name: seqdet_prog

Overview:
- Runtime-programmable serial bit-pattern detector. Generalises the fixed 4-bit Mealy detector to any pattern length.
- Adds per-load overlap/non-overlap mode, a valid-qualified input stream and a saturating detection counter.
- Sits after a serial deserialiser or bit-slicer and flags framing/sync words for downstream control logic.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..32.
- CNT_W, 8, width of the detection counter.
- RESET_PAT, 4'b1101 (PAT_LEN bits), pattern active after reset.
- RESET_OVL, 1'b1, overlap mode active after reset (1 = overlapping).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  i_data carries a stream bit this cycle.
- i_data  input  1  serial stream bit.
- cfg_load  input  1  one-cycle strobe; latches cfg_pattern and cfg_overlap.
- cfg_pattern  input  PAT_LEN  new pattern; bit PAT_LEN-1 is the first bit received, bit 0 the last.
- cfg_overlap  input  1  mode to latch: 1 = overlapping, 0 = non-overlapping.
- o_det  output  1  Mealy detect; high in the cycle the final pattern bit is presented.
- o_det_cnt  output  CNT_W  saturating count of detections since reset or load.
- o_armed  output  1  fill count >= PAT_LEN-1, i.e. the next valid bit can complete a match.

Behaviour:
- Registers:
  - pat_q (PAT_LEN)
  - ovl_q
  - hist_q (PAT_LEN-1): last valid bits, newest in bit 0
  - fill_q: width $clog2(PAT_LEN+1), saturates at PAT_LEN-1
  - cnt_q (CNT_W)
- Reset (async, any time, including mid-stream):
  - pat_q=RESET_PAT, ovl_q=RESET_OVL, hist_q=0, fill_q=0, cnt_q=0.
  - o_det=0, o_det_cnt=0, o_armed=0.
- Match condition (combinational):
  - match = i_valid & ~cfg_load & (fill_q == PAT_LEN-1) & ({hist_q, i_data} == pat_q).
  - o_det = match. Zero latency: same cycle as the last pattern bit, no registered output.
- Internal FSM: FILL (fill_q < PAT_LEN-1) and ARMED (fill_q == PAT_LEN-1). Per cycle:
  - cfg_load=1: pat_q/ovl_q take the cfg inputs; hist_q=0, fill_q=0, cnt_q=0. The simultaneous i_valid bit is discarded (load wins). o_det=0.
  - i_valid=0: all state holds; o_det=0.
  - i_valid=1, no match: hist_q <= {hist_q[PAT_LEN-3:0], i_data}; fill_q <= min(fill_q+1, PAT_LEN-1).
  - i_valid=1, match, ovl_q=1: shift as above; fill_q stays PAT_LEN-1, so a suffix of the match can start the next one.
  - i_valid=1, match, ovl_q=0: hist_q <= 0, fill_q <= 0. The next PAT_LEN valid bits are needed before another match.
  - Any match: cnt_q <= cnt_q+1, saturating at 2^CNT_W-1. No wrap.
- o_armed = (fill_q == PAT_LEN-1), registered-state derived.
- Comparison is exact bit-for-bit. A fill count below PAT_LEN-1 never matches, even if the stale history would.
- Gaps in i_valid of any length are transparent to detection.

Optional Feature:
- Macro: SEQDET_MASK_EN.
- Defined:
  - Extra input cfg_mask [PAT_LEN], latched into mask_q on cfg_load; reset value all-ones.
  - Bit positions with mask_q=0 are don't-care in the compare: (({hist_q,i_data} ^ pat_q) & mask_q) == 0.
  - All-zero mask matches every valid bit once armed.
- Undefined: no cfg_mask port; exact compare only.

Test Plan:
- Reset defaults (1101, overlap): valid stream 1,1,0,1,1,0,1 -> o_det high on bits 4 and 7 only; o_det_cnt=2.
- Load 1101 with cfg_overlap=0, same stream -> o_det high on bit 4 only; o_det_cnt=1; o_armed low after bit 4 until bit 7 is accepted.
- Load 1111 overlap, PAT_LEN=4, eight 1s -> o_det on bits 4..8 (5 pulses). Non-overlap, same stream -> pulses on bits 4 and 8.
- CNT_W=2, overlap 1111, ten 1s -> o_det_cnt stops at 3 after the 3rd detection and stays 3.
- Valid gaps and load priority:
  - Stream 1,1,0,1 with i_valid low for 5 cycles between each bit -> single o_det on the 4th valid bit; o_det=0 in every gap cycle.
  - cfg_load together with the 4th bit -> no o_det, fill_q=0, o_det_cnt=0.
- Async reset mid-stream: assert reset between bits 3 and 4 of 1101 (not on a clock edge) -> outputs 0 immediately. After release, the bit 1 alone gives no detect; a full 1101 is needed.

Source files
------------

// File: rtl/seqdet_prog_if.sv
// seqdet_prog_if: stream, configuration and detect signals of the
// programmable sequence detector. The cfg_mask field exists only when
// SEQDET_MASK_EN is defined.
interface seqdet_prog_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               i_valid;
    logic               i_data;
    logic               cfg_load;
    logic [PAT_LEN-1:0] cfg_pattern;
    logic               cfg_overlap;
`ifdef SEQDET_MASK_EN
    logic [PAT_LEN-1:0] cfg_mask;
`endif
    logic               o_det;
    logic [CNT_W-1:0]   o_det_cnt;
    logic               o_armed;

`ifdef SEQDET_MASK_EN
    modport master (
        output i_valid, i_data, cfg_load, cfg_pattern, cfg_overlap, cfg_mask,
        input  o_det, o_det_cnt, o_armed
    );
    modport slave (
        input  i_valid, i_data, cfg_load, cfg_pattern, cfg_overlap, cfg_mask,
        output o_det, o_det_cnt, o_armed
    );
`else
    modport master (
        output i_valid, i_data, cfg_load, cfg_pattern, cfg_overlap,
        input  o_det, o_det_cnt, o_armed
    );
    modport slave (
        input  i_valid, i_data, cfg_load, cfg_pattern, cfg_overlap,
        output o_det, o_det_cnt, o_armed
    );
`endif
endinterface

// File: rtl/seqdet_prog.sv
// seqdet_prog: runtime-programmable serial pattern detector (Mealy).
// Keeps the last PAT_LEN-1 valid bits and flags a match in the same cycle
// the final pattern bit arrives. Supports overlapping/non-overlapping mode
// and a saturating detection counter.
// Optional feature: define SEQDET_MASK_EN to add a per-bit don't-care mask
// (cfg_mask) to the comparison.
module seqdet_prog #(
    parameter int                 PAT_LEN   = 4,
    parameter int                 CNT_W     = 8,
    parameter logic [PAT_LEN-1:0] RESET_PAT = PAT_LEN'(4'b1101),
    parameter logic               RESET_OVL = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    seqdet_prog_if.slave  bus
);
    localparam int               FW       = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // FILL: still collecting history; ARMED: the next valid bit can complete a match.
    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    logic [PAT_LEN-1:0] pat_q,  pat_d;
    logic               ovl_q,  ovl_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
`ifdef SEQDET_MASK_EN
    logic [PAT_LEN-1:0] mask_q, mask_d;
`endif

    state_t             state;
    logic [PAT_LEN-1:0] window;
    logic               hit;
    logic               match;

    // The fill counter is the state register; the FSM state is its decode.
    assign state  = (fill_q == FILL_MAX) ? ST_ARMED : ST_FILL;

    // Candidate word: stored history followed by the bit on the wire now.
    assign window = {hist_q, bus.i_data};

`ifdef SEQDET_MASK_EN
    assign hit = ((window ^ pat_q) & mask_q) == '0;
`else
    assign hit = (window == pat_q);
`endif

    // A load in the same cycle always suppresses detection.
    assign match = bus.i_valid & ~bus.cfg_load & (state == ST_ARMED) & hit;

    assign bus.o_det     = match;
    assign bus.o_det_cnt = cnt_q;
    assign bus.o_armed   = (state == ST_ARMED);

    // Next-state logic: load, history shift, fill tracking and counting.
    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
`ifdef SEQDET_MASK_EN
        mask_d = mask_q;
`endif
        if (bus.cfg_load) begin
            pat_d  = bus.cfg_pattern;
            ovl_d  = bus.cfg_overlap;
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
`ifdef SEQDET_MASK_EN
            mask_d = bus.cfg_mask;
`endif
        end else if (bus.i_valid) begin
            hist_d = window[PAT_LEN-2:0];
            case (state)
                ST_FILL:  fill_d = fill_q + FW'(1);
                ST_ARMED: begin
                    // Non-overlapping: a match consumes its bits entirely.
                    if (match && !ovl_q) begin
                        hist_d = '0;
                        fill_d = '0;
                    end
                end
            endcase
            if (match && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous reset to the power-up configuration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q  <= RESET_PAT;
            ovl_q  <= RESET_OVL;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
`ifdef SEQDET_MASK_EN
            mask_q <= '1;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            pat_q  <= pat_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
`ifdef SEQDET_MASK_EN
            mask_q <= mask_d;
`endif
        end
    end
endmodule
